keypad_time_entry: RTL and testbench

- Parametrised successor to the microwave timer input/control front end.
- Debounces a 10-key decimal keypad, priority-encodes the highest pressed key, and shifts each accepted digit into a DIGITS-wide BCD time register.
- Emits a one-cycle active-low load strobe per accepted digit.
- Generates a gated square-wave tick from the system clock by a parametrised division ratio; the tick feeds the downstream countdown timer.

---
 rtl/keypad_time_entry.sv | 162 ++++++++++++++++
 tb/tb_keypad_time_entry.sv | 458 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_time_entry.sv
// Keypad debouncer, BCD time entry shifter and gated divided-clock tick.
// Optional ENTRY_LOCK_EN: ignore further digits once the register is full.
module keypad_time_entry #(
  parameter  int DIGITS          = 4,
  parameter  int DEBOUNCE_CYCLES = 3,
  parameter  int DIV_RATIO       = 100,
  localparam int CW              = $clog2(DIGITS + 1)
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [9:0]            key,
  input  logic                  entry_en,
  input  logic                  count_en,
  input  logic                  clear,
  output logic [4*DIGITS-1:0]   digits,
  output logic [CW-1:0]         digit_count,
  output logic [3:0]            D,
  output logic                  loadn,
  output logic                  pgt_1Hz
);

  localparam int NB   = 4 * DIGITS;
  localparam int DBW  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HALF = DIV_RATIO / 2;
  localparam int VW   = (HALF > 1) ? $clog2(HALF) : 1;

  typedef enum logic [1:0] {
    IDLE,
    DEBOUNCE,
    HELD
  } state_t;

  state_t          state_q;
  logic [3:0]      code;
  logic [3:0]      code_q;
  logic [DBW-1:0]  cnt_q;
  logic            acc_q;
  logic [NB-1:0]   digits_q;
  logic [NB-1:0]   digits_d;
  logic [CW-1:0]   count_q;
  logic [3:0]      d_q;
  logic            loadn_q;
  logic            hit;
  logic            lock;
  logic [VW-1:0]   div_q;
  logic            wave_q;
  logic            pgt_q;

  assign hit = |key;

  always_comb begin
    code = 4'd0;
    priority case (1'b1)
      key[9]:  code = 4'd9;
      key[8]:  code = 4'd8;
      key[7]:  code = 4'd7;
      key[6]:  code = 4'd6;
      key[5]:  code = 4'd5;
      key[4]:  code = 4'd4;
      key[3]:  code = 4'd3;
      key[2]:  code = 4'd2;
      key[1]:  code = 4'd1;
      key[0]:  code = 4'd0;
      default: code = 4'd0;
    endcase
  end

`ifdef ENTRY_LOCK_EN
  assign lock = (count_q == CW'(DIGITS));
`else
  assign lock = 1'b0;
`endif

  assign digits_d = (digits_q << 4) | NB'(code_q);

  // acc_q marks the DEBOUNCE->HELD edge; the digit lands one cycle later
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      code_q   <= 4'd0;
      cnt_q    <= '0;
      acc_q    <= 1'b0;
      digits_q <= '0;
      count_q  <= '0;
      d_q      <= 4'd0;
      loadn_q  <= 1'b1;
    end else begin
      loadn_q <= 1'b1;
      acc_q   <= 1'b0;
      if (clear) begin
        state_q  <= IDLE;
        digits_q <= '0;
        count_q  <= '0;
      end else begin
        if (acc_q && !lock) begin
          digits_q <= digits_d;
          d_q      <= code_q;
          loadn_q  <= 1'b0;
          if (count_q != CW'(DIGITS))
            count_q <= count_q + CW'(1);
        end
        unique case (state_q)
          IDLE: begin
            if (hit && entry_en) begin
              code_q <= code;
              cnt_q  <= DBW'(1);
              if (DEBOUNCE_CYCLES == 1) begin
                state_q <= HELD;
                acc_q   <= 1'b1;
              end else begin
                state_q <= DEBOUNCE;
              end
            end
          end
          DEBOUNCE: begin
            if (!hit || !entry_en) begin
              state_q <= IDLE;
            end else if (code != code_q) begin
              code_q <= code;
              cnt_q  <= DBW'(1);
            end else begin
              cnt_q <= cnt_q + DBW'(1);
              if (cnt_q == DBW'(DEBOUNCE_CYCLES - 1)) begin
                state_q <= HELD;
                acc_q   <= 1'b1;
              end
            end
          end
          HELD: begin
            if (!hit)
              state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  // free-running phase; count_en only gates the registered output
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      div_q  <= '0;
      wave_q <= 1'b0;
      pgt_q  <= 1'b0;
    end else begin
      if (div_q == VW'(HALF - 1)) begin
        div_q  <= '0;
        wave_q <= ~wave_q;
      end else begin
        div_q <= div_q + VW'(1);
      end
      pgt_q <= wave_q & count_en;
    end
  end

  assign digits      = digits_q;
  assign digit_count = count_q;
  assign D           = d_q;
  assign loadn       = loadn_q;
  assign pgt_1Hz     = pgt_q;

endmodule

// File: tb/tb_keypad_time_entry.sv
// Scoreboard bench for keypad_time_entry (DIGITS=4, debounce 3, divide 10).
// Expected digit snapshots are queued at press time and compared on loadn.
module tb_keypad_time_entry;

  localparam int DIGITS = 4;
  localparam int DEB    = 3;
  localparam int DIV    = 10;

  logic        clk = 1'b0;
  logic        resetn;
  logic [9:0]  key;
  logic        entry_en;
  logic        count_en;
  logic        clear;
  logic [15:0] digits;
  logic [2:0]  digit_count;
  logic [3:0]  D;
  logic        loadn;
  logic        pgt_1Hz;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [15:0] dg;
    logic [2:0]  cnt;
    logic [3:0]  d;
  } snap_t;

  snap_t exp_q[$];
  snap_t obs_q[$];

  logic [15:0] m_dg;
  logic [2:0]  m_cnt;
  logic [3:0]  m_d;

  keypad_time_entry #(
    .DIGITS(DIGITS),
    .DEBOUNCE_CYCLES(DEB),
    .DIV_RATIO(DIV)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .key(key),
    .entry_en(entry_en),
    .count_en(count_en),
    .clear(clear),
    .digits(digits),
    .digit_count(digit_count),
    .D(D),
    .loadn(loadn),
    .pgt_1Hz(pgt_1Hz)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    m_dg  = 16'h0;
    m_cnt = 3'd0;
  endtask

  task automatic expect_digit(input logic [3:0] k);
`ifdef ENTRY_LOCK_EN
    if (m_cnt == 3'd4) return;
`endif
    m_dg = {m_dg[11:0], k};
    m_d  = k;
    if (m_cnt < 3'd4) m_cnt++;
    exp_q.push_back({m_dg, m_cnt, m_d});
  endtask

  task automatic press(input logic [9:0] k, input int hold,
                       output int pulses);
    pulses = 0;
    key = k;
    for (int i = 0; i < hold + 4; i++) begin
      tick();
      if (i == hold - 1) key = 10'h0;
      if (loadn === 1'b0) begin
        pulses++;
        obs_q.push_back({digits, digit_count, D});
      end
    end
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    model_clear();
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    #12;
    checks++;
    if ({digits, digit_count, D} !== 23'h0) begin
      errors++;
      $display("FAIL reset_regs: got %h want 0",
               {digits, digit_count, D});
    end
    checks++;
    if (loadn !== 1'b1) begin
      errors++;
      $display("FAIL reset_loadn: got %b want 1", loadn);
    end
    checks++;
    if (pgt_1Hz !== 1'b0) begin
      errors++;
      $display("FAIL reset_pgt: got %b want 0", pgt_1Hz);
    end
    @(negedge clk);
    resetn = 1'b1;
    tick();
  endtask

  task automatic test_latency();
    int n_low;
    int first_low;
    snap_t o, e;
    n_low = 0;
    first_low = -1;
    key = 10'h008;
    expect_digit(4'd3);
    for (int c = 1; c <= 9; c++) begin
      tick();
      if (loadn === 1'b0) begin
        n_low++;
        first_low = c;
        obs_q.push_back({digits, digit_count, D});
      end
      if (c == 5) key = 10'h0;
    end
    checks++;
    if (n_low != 1) begin
      errors++;
      $display("FAIL latency_pulses: got %0d want 1", n_low);
    end
    checks++;
    if (first_low != DEB + 1) begin
      errors++;
      $display("FAIL latency_cycle: got %0d want %0d", first_low, DEB + 1);
    end
    checks++;
    if (obs_q.size() == 0) begin
      errors++;
      $display("FAIL latency_snap: got none want %h", exp_q[0]);
      exp_q.delete();
    end else begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      if (o !== e) begin
        errors++;
        $display("FAIL latency_snap: got %h want %h", o, e);
      end
    end
  endtask

  task automatic test_sequence();
    logic [3:0] seq [5];
    int p;
    int want;
    logic [15:0] final_dg;
    snap_t o, e;
    seq = '{4'd1, 4'd2, 4'd0, 4'd5, 4'd9};
    do_clear();
    checks++;
    if ({digits, digit_count} !== 19'h0 || D !== 4'd3) begin
      errors++;
      $display("FAIL clear_state: got %h/%h want 0/3",
               {digits, digit_count}, D);
    end
    for (int i = 0; i < 5; i++) begin
      want = exp_q.size();
      expect_digit(seq[i]);
      want = exp_q.size() - want;
      press(10'b1 << seq[i], 5, p);
      checks++;
      if (p != want) begin
        errors++;
        $display("FAIL seq_pulses[%0d]: got %0d want %0d", i, p, want);
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
        o = obs_q.pop_front();
        e = exp_q.pop_front();
        checks++;
        if (o !== e) begin
          errors++;
          $display("FAIL seq_snap[%0d]: got %h want %h", i, o, e);
        end
      end
      exp_q.delete();
      obs_q.delete();
    end
`ifdef ENTRY_LOCK_EN
    final_dg = 16'h1205;
`else
    final_dg = 16'h2059;
`endif
    checks++;
    if (digits !== final_dg || digit_count !== 3'd4) begin
      errors++;
      $display("FAIL seq_final: got %h/%0d want %h/4",
               digits, digit_count, final_dg);
    end
  endtask

  task automatic test_bounce();
    logic [9:0] pat [11];
    int p;
    snap_t o, e;
    pat = '{10'h004, 10'h004, 10'h000, 10'h004, 10'h004, 10'h004,
            10'h000, 10'h000, 10'h000, 10'h000, 10'h000};
    do_clear();
    expect_digit(4'd2);
    p = 0;
    for (int i = 0; i < 11; i++) begin
      key = pat[i];
      tick();
      if (loadn === 1'b0) begin
        p++;
        obs_q.push_back({digits, digit_count, D});
      end
    end
    checks++;
    if (p != 1) begin
      errors++;
      $display("FAIL bounce_pulses: got %0d want 1", p);
    end
    if (obs_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL bounce_snap: got %h want %h", o, e);
      end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_simultaneous();
    int p;
    snap_t o, e;
    expect_digit(4'd9);
    press(10'h201, 20, p);
    checks++;
    if (p != 1) begin
      errors++;
      $display("FAIL simul_pulses: got %0d want 1", p);
    end
    if (obs_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL simul_snap: got %h want %h", o, e);
      end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_clear_race();
    int p;
    p = 0;
    key = 10'h080;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (loadn === 1'b0) p++;
      if (c == DEB) begin
        clear = 1'b1;
        key = 10'h0;
      end else begin
        clear = 1'b0;
      end
    end
    model_clear();
    checks++;
    if (p != 0) begin
      errors++;
      $display("FAIL clear_race_pulses: got %0d want 0", p);
    end
    checks++;
    if ({digits, digit_count} !== 19'h0 || D !== 4'd9) begin
      errors++;
      $display("FAIL clear_race_state: got %h/%h want 0/9",
               {digits, digit_count}, D);
    end
  endtask

  task automatic test_divider();
    int c;
    int fall_at;
    int rise_at;
    int highs;
    logic prev;
    logic ok;
    count_en = 1'b1;
    ok = 1'b0;
    prev = pgt_1Hz;
    for (int i = 0; i < 40 && !ok; i++) begin
      tick();
      if (prev && !pgt_1Hz) ok = 1'b1;
      prev = pgt_1Hz;
    end
    for (int i = 0; i < 20 && ok; i++) begin
      tick();
      if (pgt_1Hz) break;
    end
    checks++;
    if (!ok || pgt_1Hz !== 1'b1) begin
      errors++;
      $display("FAIL div_lock: got no rising edge want rise in 60 cycles");
    end
    fall_at = -1;
    rise_at = -1;
    prev = 1'b1;
    for (c = 1; c <= 10; c++) begin
      tick();
      if (prev && !pgt_1Hz && fall_at < 0) fall_at = c;
      if (!prev && pgt_1Hz && rise_at < 0) rise_at = c;
      prev = pgt_1Hz;
    end
    checks++;
    if (fall_at != DIV / 2) begin
      errors++;
      $display("FAIL div_duty: got fall at %0d want %0d", fall_at, DIV / 2);
    end
    checks++;
    if (rise_at != DIV) begin
      errors++;
      $display("FAIL div_period: got rise at %0d want %0d", rise_at, DIV);
    end
    tick();
    tick();
    count_en = 1'b0;
    tick();
    checks++;
    if (pgt_1Hz !== 1'b0) begin
      errors++;
      $display("FAIL div_gate: got %b want 0", pgt_1Hz);
    end
    highs = 0;
    for (c = 14; c <= 16; c++) begin
      tick();
      if (pgt_1Hz) highs++;
    end
    count_en = 1'b1;
    rise_at = -1;
    prev = pgt_1Hz;
    for (c = 17; c <= 40 && rise_at < 0; c++) begin
      tick();
      if (!prev && pgt_1Hz) rise_at = c;
      prev = pgt_1Hz;
    end
    checks++;
    if (highs != 0) begin
      errors++;
      $display("FAIL div_gated_low: got %0d highs want 0", highs);
    end
    checks++;
    if (rise_at != 2 * DIV) begin
      errors++;
      $display("FAIL div_phase: got rise at %0d want %0d", rise_at, 2 * DIV);
    end
  endtask

  task automatic test_reset_mid();
    int p;
    logic seen;
    snap_t o, e;
    expect_digit(4'd6);
    press(10'h040, 5, p);
    checks++;
    if (p != 1 || obs_q.size() == 0) begin
      errors++;
      $display("FAIL pre_reset_pulses: got %0d want 1", p);
    end else begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      if (o !== e) begin
        errors++;
        $display("FAIL pre_reset_snap: got %h want %h", o, e);
      end
    end
    exp_q.delete();
    obs_q.delete();
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      tick();
      if (!pgt_1Hz) seen = 1'b1;
    end
    for (int i = 0; i < 30 && seen; i++) begin
      tick();
      if (pgt_1Hz) break;
    end
    key = 10'h010;
    tick();
    tick();
    #2;
    resetn = 1'b0;
    #1;
    checks++;
    if ({digits, digit_count, D} !== 23'h0) begin
      errors++;
      $display("FAIL async_reset_regs: got %h want 0",
               {digits, digit_count, D});
    end
    checks++;
    if (loadn !== 1'b1 || pgt_1Hz !== 1'b0) begin
      errors++;
      $display("FAIL async_reset_outs: got loadn=%b pgt=%b want 1/0",
               loadn, pgt_1Hz);
    end
    key = 10'h0;
    @(negedge clk);
    resetn = 1'b1;
    p = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (loadn === 1'b0) p++;
    end
    checks++;
    if (p != 0) begin
      errors++;
      $display("FAIL pending_lost: got %0d pulses want 0", p);
    end
  endtask

  initial begin
    key = 10'h0;
    entry_en = 1'b1;
    count_en = 1'b0;
    clear = 1'b0;
    resetn = 1'b0;
    m_d = 4'd0;
    model_clear();
    test_reset();
    test_latency();
    test_sequence();
    test_bounce();
    test_simultaneous();
    test_clear_race();
    test_divider();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
